// File: rtl/clock_phase_gen.sv
// Emulated-time clock source: fires an event when global time reaches this
// clock's next edge, steps its own edge time and rotates a one-hot phase enable.
`timescale 1ns/1ps
module clock_phase_gen #(
  parameter int N_PHASES      = 2,
  parameter int TIME_WIDTH    = 32,
  parameter int TIME_INC_BITS = 16,
  parameter int INC_RESET     = 1,
  parameter int CNT_WIDTH     = 32,
  localparam int PH_W = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
  input  logic                     clk_sys,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic [TIME_WIDTH-1:0]    time_next,
  input  logic [TIME_INC_BITS-1:0] inc,
  input  logic                     inc_wr,
  output logic [TIME_WIDTH-1:0]    time_clock,
  output logic                     time_eq,
  output logic [PH_W-1:0]          phase_idx,
  output logic [N_PHASES-1:0]      clk_en,
  output logic                     inc_pend,
  output logic [CNT_WIDTH-1:0]     edge_cnt
);

  generate
    if (N_PHASES < 1 || N_PHASES > 16) begin : g_bad_phases
      $error("clock_phase_gen: N_PHASES must be in 1..16");
    end
  endgenerate

  logic [TIME_WIDTH-1:0]    time_clock_reg;
  logic [PH_W-1:0]          phase_idx_reg;
  logic [N_PHASES-1:0]      clk_en_reg;
  logic [N_PHASES-1:0]      clk_en_next;
  logic [TIME_INC_BITS-1:0] inc_active_reg;
  logic [TIME_INC_BITS-1:0] inc_shadow_reg;
  logic                     inc_pend_reg;
  logic [CNT_WIDTH-1:0]     edge_cnt_reg;
  logic [PH_W-1:0]          phase_idx_next;

  assign time_eq = run && (time_next == time_clock_reg);

  genvar gi;
  generate
    for (gi = 0; gi < N_PHASES; gi++) begin : g_en
      assign clk_en_next[gi] = time_eq && (phase_idx_reg == PH_W'(gi));
    end
  endgenerate

  // The single-phase case collapses to a constant 0 because N_PHASES-1 == 0.
  assign phase_idx_next = (phase_idx_reg == PH_W'(N_PHASES - 1)) ? '0
                                                                  : phase_idx_reg + PH_W'(1);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      time_clock_reg <= '0;
      phase_idx_reg  <= '0;
      clk_en_reg     <= '0;
      inc_active_reg <= TIME_INC_BITS'(INC_RESET);
      inc_shadow_reg <= '0;
      inc_pend_reg   <= 1'b0;
      edge_cnt_reg   <= '0;
    end else begin
      clk_en_reg <= clk_en_next;
      if (time_eq) begin
        time_clock_reg <= time_clock_reg + TIME_WIDTH'(inc_active_reg);
        phase_idx_reg  <= phase_idx_next;
        edge_cnt_reg   <= edge_cnt_reg + CNT_WIDTH'(1);
        if (inc_pend_reg)
          inc_active_reg <= inc_shadow_reg;
      end
      // A write landing on an event stays pending; the older shadow was applied above.
      if (inc_wr) begin
        inc_shadow_reg <= inc;
        inc_pend_reg   <= 1'b1;
      end else if (time_eq) begin
        inc_pend_reg   <= 1'b0;
      end
    end
  end

  assign time_clock = time_clock_reg;
  assign phase_idx  = phase_idx_reg;
  assign clk_en     = clk_en_reg;
  assign inc_pend   = inc_pend_reg;
  assign edge_cnt   = edge_cnt_reg;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Scoreboard bench for clock_phase_gen: 3 phases, 8-bit time, reset increment 5.
`timescale 1ns/1ps
module tb_clock_phase_gen;

  localparam int NP = 3;
  localparam int TW = 8;
  localparam int IB = 8;
  localparam int CW = 8;

  logic          clk_sys = 1'b0;
  logic          rst_n;
  logic          run;
  logic [TW-1:0] time_next;
  logic [IB-1:0] inc;
  logic          inc_wr;
  logic [TW-1:0] time_clock;
  logic          time_eq;
  logic [1:0]    phase_idx;
  logic [NP-1:0] clk_en;
  logic          inc_pend;
  logic [CW-1:0] edge_cnt;

  clock_phase_gen #(
    .N_PHASES(NP), .TIME_WIDTH(TW), .TIME_INC_BITS(IB), .INC_RESET(5), .CNT_WIDTH(CW)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .run(run), .time_next(time_next),
    .inc(inc), .inc_wr(inc_wr), .time_clock(time_clock), .time_eq(time_eq),
    .phase_idx(phase_idx), .clk_en(clk_en), .inc_pend(inc_pend), .edge_cnt(edge_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [TW-1:0] t;
    logic [1:0]    ph;
    logic [NP-1:0] en;
    logic          pend;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  logic [TW-1:0] m_time;
  logic [1:0]    m_phase;
  logic [IB-1:0] m_active;
  logic [IB-1:0] m_shadow;
  logic          m_pend;
  logic [CW-1:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_time = '0; m_phase = '0; m_active = 8'd5; m_shadow = '0; m_pend = 1'b0; m_cnt = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_time"}, 32'(time_clock), 32'd0);
    check_eq({tag, "_ph"},   32'(phase_idx),  32'd0);
    check_eq({tag, "_en"},   32'(clk_en),     32'd0);
    check_eq({tag, "_pend"}, 32'(inc_pend),   32'd0);
    check_eq({tag, "_cnt"},  32'(edge_cnt),   32'd0);
  endtask

  // One clk_sys cycle: drive at negedge, predict, compare after the posedge.
  task automatic step(input logic r, input logic [TW-1:0] tn, input logic w, input logic [IB-1:0] iv);
    logic eq;
    exp_t e, x;
    @(negedge clk_sys);
    run = r; time_next = tn; inc_wr = w; inc = iv;
    #1;
    eq = r && (tn == m_time);
    check_eq("time_eq", 32'(time_eq), 32'(eq));
    e.en = eq ? NP'(1 << m_phase) : '0;
    if (eq) begin
      m_time  = m_time + TW'(m_active);
      m_phase = (m_phase == 2'(NP - 1)) ? 2'd0 : m_phase + 2'd1;
      m_cnt   = m_cnt + 1'b1;
      if (m_pend) m_active = m_shadow;
    end
    if (w) begin
      m_shadow = iv; m_pend = 1'b1;
    end else if (eq) begin
      m_pend = 1'b0;
    end
    e.t = m_time; e.ph = m_phase; e.pend = m_pend; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk_sys);
    #1;
    x = sb.pop_front();
    check_eq("time_clock", 32'(time_clock), 32'(x.t));
    check_eq("phase_idx",  32'(phase_idx),  32'(x.ph));
    check_eq("clk_en",     32'(clk_en),     32'(x.en));
    check_eq("inc_pend",   32'(inc_pend),   32'(x.pend));
    check_eq("edge_cnt",   32'(edge_cnt),   32'(x.cnt));
    $display("cyc run=%0b tn=%0h wr=%0b eq=%0b time=%0h ph=%0d en=%b pend=%0b cnt=%0d",
             r, tn, w, eq, time_clock, phase_idx, clk_en, inc_pend, edge_cnt);
  endtask

  task automatic ev();
    step(1'b1, m_time, 1'b0, '0);
  endtask

  task automatic idle();
    step(1'b1, m_time + 8'd1, 1'b0, '0);
  endtask

  initial begin
    logic [IB-1:0] x_inc;
    rst_n = 1'b0; run = 1'b0; time_next = '0; inc = '0; inc_wr = 1'b0;
    model_reset();
    #3;
    check_reset_vals("rst");
    check_eq("rst_time_eq", 32'(time_eq), 32'd0);
    #9 rst_n = 1'b1;

    // tracking: edges at 0,5,10,15 with phases 0,1,2,0
    check_eq("first_eq", 32'(time_eq), 32'd0);
    ev(); ev(); ev(); ev();
    check_eq("t_after4", 32'(time_clock), 32'd20);
    check_eq("cnt_after4", 32'(edge_cnt), 32'd4);
    check_eq("ph_after4", 32'(phase_idx), 32'd1);

    // increment update: write 7 between events
    idle();
    step(1'b1, m_time + 8'd3, 1'b1, 8'd7);
    check_eq("pend_set", 32'(inc_pend), 32'd1);
    ev();
    check_eq("t_old_inc", 32'(time_clock), 32'd25);
    check_eq("pend_clr", 32'(inc_pend), 32'd0);
    ev();
    check_eq("t_new_inc", 32'(time_clock), 32'd32);

    // run low for 10 cycles, with a write accepted meanwhile
    for (int i = 0; i < 10; i++)
      step(1'b0, m_time, (i == 4), 8'd3);
    check_eq("frozen_t", 32'(time_clock), 32'd32);
    check_eq("frozen_cnt", 32'(edge_cnt), 32'd6);
    check_eq("pend_while_stopped", 32'(inc_pend), 32'd1);
    ev(); ev(); ev();

    // zero increment: event on every cycle while time_next holds
    step(1'b1, m_time + 8'd9, 1'b1, 8'd0);
    ev(); ev(); ev(); ev(); ev();
    check_eq("zero_inc_t", 32'(time_clock), 32'(m_time));

    // steer time_clock to 0xFE with inc_active=4, then write during the event
    x_inc = 8'hFE - m_time - m_active;
    step(1'b1, m_time + 8'd1, 1'b1, x_inc);
    ev();
    step(1'b1, m_time + 8'd1, 1'b1, 8'd4);
    ev();
    check_eq("at_fe", 32'(time_clock), 32'hFE);
    step(1'b1, m_time, 1'b1, 8'd9);
    check_eq("wrap_t", 32'(time_clock), 32'h02);
    check_eq("wrap_pend", 32'(inc_pend), 32'd1);
    ev();
    check_eq("wrap_next", 32'(time_clock), 32'h06);
    ev();
    check_eq("after_9", 32'(time_clock), 32'h0F);

    // randomized mix
    for (int i = 0; i < 40; i++)
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? m_time : 8'($urandom),
           ($urandom_range(0, 4) == 0), 8'($urandom_range(0, 12)));

    // asynchronous reset pulse while an event is being presented
    @(negedge clk_sys);
    run = 1'b1; time_next = m_time; inc_wr = 1'b0;
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    model_reset();
    @(posedge clk_sys);
    #1;
    check_eq("discard_cnt", 32'(edge_cnt), (time_next == 8'd0) ? 32'd1 : 32'd0);
    if (time_next == 8'd0) begin
      m_time = m_active; m_phase = 2'd1; m_cnt = 8'd1;
    end
    ev(); ev(); ev();
    check_eq("post_rst_ph", 32'(phase_idx), 32'(m_phase));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
